// File: rtl/override_arbiter_pkg.sv
// Shared types and default parameters for the override arbiter.
package override_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OVERRIDE = 2'd1,
        RELEASE  = 2'd2
    } ovr_state_e;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_MAX_HOLD = 64;

endpackage

// File: rtl/override_arbiter_if.sv
// Normal-path, override-request and status signals of the override arbiter.
interface override_arbiter_if
    import override_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic                   cnt_en;
    logic                   wr_en;
    logic [WIDTH-1:0]       wr_data;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] ovr_val;
    logic [WIDTH-1:0]       value;
    logic [N_REQ-1:0]       gnt;
    logic                   ovr_active;
    logic                   wr_blocked;
    logic                   timeout;

    modport master (
        output cnt_en, wr_en, wr_data, req, ovr_val,
        input  value, gnt, ovr_active, wr_blocked, timeout
    );

    modport slave (
        input  cnt_en, wr_en, wr_data, req, ovr_val,
        output value, gnt, ovr_active, wr_blocked, timeout
    );

endinterface

// File: rtl/override_arbiter_rr.sv
// Round-robin selector: first unmasked request strictly after the last winner.
module rr_arbiter
    import override_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_REQ-1:0] elig;

    assign elig = req_i & ~mask_i;

    always_comb begin : search
        int unsigned cand;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_i) + k) % N_REQ;
            if (!found && elig[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                gnt_o[cand[IDX_W-1:0]]   = 1'b1;
                idx_o                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/override_arbiter.sv
// Managed register with a normal write/count path and round-robin arbitrated
// override requesters, including hold-time limiting and a one-cycle release gap.
module override_arbiter
    import override_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    override_arbiter_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    ovr_state_e        state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              blk_q, blk_d;
    logic              to_q, to_d;
    logic [N_REQ-1:0]  mask_q, mask_d;

    logic [N_REQ-1:0]  rr_gnt;
    logic [IDX_W-1:0]  rr_idx;
    logic              normal_op;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i  (bus.req),
        .mask_i (mask_q),
        .ptr_i  (last_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx)
    );

    assign normal_op = bus.wr_en | bus.cnt_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            gnt_q   <= '0;
            win_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
            blk_q   <= 1'b0;
            to_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            blk_q   <= blk_d;
            to_q    <= to_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        gnt_d   = gnt_q;
        win_d   = win_q;
        last_d  = last_q;
        hold_d  = hold_q;
        blk_d   = blk_q;
        to_d    = 1'b0;
        // A timed-out requester becomes eligible again once it has dropped req.
        mask_d  = mask_q & bus.req;

        unique case (state_q)
            IDLE: begin
                if (|rr_gnt) begin
                    state_d = OVERRIDE;
                    gnt_d   = rr_gnt;
                    win_d   = rr_idx;
                    last_d  = rr_idx;
                    value_d = bus.ovr_val[32'(rr_idx) * WIDTH +: WIDTH];
                    hold_d  = HOLD_W'(1);
                    if (normal_op) blk_d = 1'b1;
                end else if (bus.wr_en) begin
                    value_d = bus.wr_data;
                end else if (bus.cnt_en) begin
                    value_d = value_q + WIDTH'(1);
                end
            end
            OVERRIDE: begin
                if (normal_op) blk_d = 1'b1;
                if (!bus.req[win_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    hold_d  = '0;
                    // A voluntary drop on the limit cycle is a plain release.
                    if (bus.req[win_q]) begin
                        to_d          = 1'b1;
                        mask_d[win_q] = 1'b1;
                    end
                end else begin
                    value_d = bus.ovr_val[32'(win_q) * WIDTH +: WIDTH];
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.value      = value_q;
    assign bus.gnt        = gnt_q;
    assign bus.ovr_active = |gnt_q;
    assign bus.wr_blocked = blk_q;
    assign bus.timeout    = to_q;

endmodule

// File: tb/tb_override_arbiter.sv
// Directed bench for override_arbiter (N_REQ=4, WIDTH=32, MAX_HOLD=16).
module tb_override_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    override_arbiter_if #(.N_REQ(4), .WIDTH(32)) bus ();

    override_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_HOLD(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.cnt_en  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.req     = '0;
        bus.ovr_val = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.value !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_value: got %0h expected 0", bus.value);
        end
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.ovr_active !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_gnt: got gnt=%b act=%b expected 0000/0", bus.gnt, bus.ovr_active);
        end
        vectors++;
        if (bus.wr_blocked !== 1'b0 || bus.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flags: got blk=%b to=%b expected 0/0", bus.wr_blocked, bus.timeout);
        end
    endtask

    task automatic test_count();
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        vectors++;
        if (bus.value !== 32'd100) begin
            miscompares++;
            $display("FAIL count100: got %0d expected 100", bus.value);
        end
        bus.cnt_en  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hFFFF_FFFF;
        tick();
        vectors++;
        if (bus.value !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL write_ones: got %0h expected ffffffff", bus.value);
        end
        bus.wr_en  = 1'b0;
        bus.cnt_en = 1'b1;
        tick();
        vectors++;
        if (bus.value !== 32'd0) begin
            miscompares++;
            $display("FAIL count_wrap: got %0h expected 0", bus.value);
        end
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'd5;
        tick();
        vectors++;
        if (bus.value !== 32'd5) begin
            miscompares++;
            $display("FAIL wr_priority: got %0h expected 5", bus.value);
        end
        bus.wr_en  = 1'b0;
        bus.cnt_en = 1'b0;
        tick();
        vectors++;
        if (bus.value !== 32'd5 || bus.wr_blocked !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: got val=%0h blk=%b expected 5/0", bus.value, bus.wr_blocked);
        end
    endtask

    task automatic test_override();
        bus.req             = 4'b0010;
        bus.ovr_val[32 +: 32] = 32'd1;
        bus.wr_en           = 1'b1;
        bus.wr_data         = 32'd0;
        tick();
        vectors++;
        if (bus.value !== 32'd1 || bus.gnt !== 4'b0010 || bus.wr_blocked !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_grant: got val=%0h gnt=%b blk=%b expected 1/0010/1",
                     bus.value, bus.gnt, bus.wr_blocked);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.value !== 32'd1 || bus.gnt !== 4'b0010 || bus.ovr_active !== 1'b1) begin
                miscompares++;
                $display("FAIL ovr_hold: got val=%0h gnt=%b act=%b expected 1/0010/1",
                         bus.value, bus.gnt, bus.ovr_active);
            end
        end
        bus.ovr_val[32 +: 32] = 32'd7;
        tick();
        vectors++;
        if (bus.value !== 32'd7) begin
            miscompares++;
            $display("FAIL ovr_track: got %0h expected 7", bus.value);
        end
        bus.ovr_val[32 +: 32] = 32'd1;
        bus.req               = 4'b0011;
        tick();
        vectors++;
        if (bus.value !== 32'd1 || bus.gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL no_preempt: got val=%0h gnt=%b expected 1/0010", bus.value, bus.gnt);
        end
    endtask

    task automatic test_release();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'd2;
        exp_seq[1] = 32'd3;
        exp_seq[2] = 32'd4;
        bus.req    = 4'b0000;
        bus.wr_en  = 1'b0;
        bus.cnt_en = 1'b1;
        tick();
        vectors++;
        if (bus.value !== 32'd1 || bus.gnt !== 4'b0000 || bus.ovr_active !== 1'b0) begin
            miscompares++;
            $display("FAIL rel_enter: got val=%0h gnt=%b act=%b expected 1/0000/0",
                     bus.value, bus.gnt, bus.ovr_active);
        end
        tick();
        vectors++;
        if (bus.value !== 32'd1) begin
            miscompares++;
            $display("FAIL rel_hold: got %0h expected 1", bus.value);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.value !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL rel_count: got %0h expected %0h", bus.value, exp_seq[i]);
            end
        end
        bus.cnt_en = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.ovr_val[0  +: 32] = 32'h10;
        bus.ovr_val[64 +: 32] = 32'h30;
        bus.ovr_val[96 +: 32] = 32'h40;
        bus.req = 4'b0101;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.value !== 32'h10) begin
            miscompares++;
            $display("FAIL rr_first: got gnt=%b val=%0h expected 0001/10", bus.gnt, bus.value);
        end
        bus.req = 4'b0100;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.value !== 32'h10) begin
            miscompares++;
            $display("FAIL rr_release: got gnt=%b val=%0h expected 0000/10", bus.gnt, bus.value);
        end
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_gap: got gnt=%b expected 0000", bus.gnt);
        end
        tick();
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.value !== 32'h30) begin
            miscompares++;
            $display("FAIL rr_second: got gnt=%b val=%0h expected 0100/30", bus.gnt, bus.value);
        end
        bus.req = 4'b0000;
        tick();
        tick();
        bus.req = 4'b1001;
        tick();
        vectors++;
        if (bus.gnt !== 4'b1000 || bus.value !== 32'h40) begin
            miscompares++;
            $display("FAIL rr_rotate: got gnt=%b val=%0h expected 1000/40", bus.gnt, bus.value);
        end
        vectors++;
        if (bus.wr_blocked !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_noblock: got %b expected 0", bus.wr_blocked);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.ovr_val[96 +: 32] = 32'hAB;
        bus.req = 4'b1000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b1000 || bus.value !== 32'hAB) begin
            miscompares++;
            $display("FAIL to_grant: got gnt=%b val=%0h expected 1000/ab", bus.gnt, bus.value);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (bus.gnt !== 4'b1000 || bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL to_holding: cycle %0d got gnt=%b to=%b expected 1000/0",
                         i + 2, bus.gnt, bus.timeout);
            end
        end
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1 || bus.value !== 32'hAB) begin
            miscompares++;
            $display("FAIL to_pulse: got gnt=%b to=%b val=%0h expected 0000/1/ab",
                     bus.gnt, bus.timeout, bus.value);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL to_masked: got gnt=%b to=%b expected 0000/0", bus.gnt, bus.timeout);
            end
        end
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL to_regrant: got gnt=%b expected 1000", bus.gnt);
        end
        for (int i = 0; i < 15; i++) tick();
        bus.req = 4'b0000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL to_simul: got gnt=%b to=%b expected 0000/0", bus.gnt, bus.timeout);
        end
        tick();
        bus.req = 4'b1000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL to_nomask: got gnt=%b expected 1000", bus.gnt);
        end
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.ovr_val[64 +: 32] = 32'hAA;
        bus.req   = 4'b0100;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.value !== 32'hAA || bus.wr_blocked !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: got gnt=%b val=%0h blk=%b expected 0100/aa/1",
                     bus.gnt, bus.value, bus.wr_blocked);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.value !== 32'd0 || bus.gnt !== 4'b0000 || bus.ovr_active !== 1'b0
            || bus.wr_blocked !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got val=%0h gnt=%b act=%b blk=%b expected 0/0000/0/0",
                     bus.value, bus.gnt, bus.ovr_active, bus.wr_blocked);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.value !== 32'hAA) begin
            miscompares++;
            $display("FAIL mid_first_grant: got gnt=%b val=%0h expected 0100/aa", bus.gnt, bus.value);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_count();
        test_override();
        test_release();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/override_arbiter.md
OVERRIDE_ARBITER -- requirements
Module: override_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of override requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, width of the managed register.
REQ-003 SHALL have parameter MAX_HOLD, default 64, maximum number of consecutive override cycles (>=2).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cnt_en  input  1  normal path: increment the register by 1.
REQ-007 wr_en  input  1  normal path: load wr_data (priority over cnt_en).
REQ-008 wr_data  input  WIDTH  normal-path write value.
REQ-009 req  input  N_REQ  level override request per requester; holding it high means assign, dropping it means deassign.
REQ-010 ovr_val  input  N_REQ*WIDTH  override value per requester; slice i is bits [i*WIDTH +: WIDTH].
REQ-011 value  output  WIDTH  managed register.
REQ-012 gnt  output  N_REQ  one-hot grant; all zero when no override is active.
REQ-013 ovr_active  output  1  high while state is OVERRIDE.
REQ-014 wr_blocked  output  1  sticky: a normal-path op was dropped during override; cleared only by reset.
REQ-015 timeout  output  1  one-cycle pulse when an override is force-released at MAX_HOLD.

Function
REQ-016 SHALL implement the states IDLE, OVERRIDE and RELEASE.
REQ-017 IDLE with no eligible request: value <= wr_data if wr_en; else value+1 if cnt_en; else hold; addition wraps modulo 2^WIDTH (all-ones + 1 = 0).
REQ-018 IDLE with any eligible request: the next edge selects a winner round-robin, sets gnt[winner], loads value <= ovr_val[winner], enters OVERRIDE, and drops any normal op in that cycle (setting wr_blocked if wr_en or cnt_en).
REQ-019 Round-robin: search starts at the index after the last winner; after reset the search starts at index 0.
REQ-020 OVERRIDE: every edge loads value <= ovr_val[winner], so value tracks the slice continuously with 1-cycle latency; wr_en and cnt_en are ignored and set wr_blocked.
REQ-021 No preemption: other requests never change gnt during OVERRIDE.
REQ-022 Winner drops req at cycle t: edge t+1 clears gnt, enters RELEASE, and holds value at the last override value.
REQ-023 RELEASE lasts exactly one cycle: value holds, no grant is issued, normal ops are ignored without flagging; the state then returns to IDLE.
REQ-024 hold counter: counts OVERRIDE cycles; when it reaches MAX_HOLD, the next edge behaves as a release (per REQ-022) and pulses timeout.
REQ-025 A timed-out requester SHALL be ineligible until it has deasserted req for at least one cycle.
REQ-026 A simultaneous release and timeout count as a release only; timeout stays low.
REQ-027 gnt SHALL always be one-hot or zero; ovr_active == |gnt.

Reset
REQ-028 rst high at an edge, in any state including mid-override, SHALL set: value=0, gnt=0, state=IDLE, rr pointer=last winner N_REQ-1, hold counter=0, wr_blocked=0, timeout=0, timeout masks cleared.
REQ-029 rst SHALL take priority over all other inputs; the first grant is possible at the first edge after rst falls.

Structure
REQ-030 A shared package override_pkg SHALL hold the state enum (IDLE/OVERRIDE/RELEASE) and default parameter constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, mask and pointer; outputs one-hot grant and index), instantiated once.
REQ-032 The block SHALL be fully synthesizable, with no procedural continuous assignment constructs.

Verification
REQ-033 Reset, then cnt_en=1 for 100 cycles -> value=100; then wr_en=1 with wr_data=0xFFFFFFFF, then cnt_en one cycle -> value=0.
REQ-034 value=5, req[1]=1 with ovr_val[1]=1, wr_en=1 with wr_data=0 during override -> value=1 every cycle, gnt=0b0010, wr_blocked=1.
REQ-035 In REQ-034, drop req[1] -> value stays 1 through the RELEASE cycle; with cnt_en=1 value then goes 2, 3, 4.
REQ-036 req[0] and req[2] rise together after reset -> gnt=0b0001 first; drop req[0] -> one RELEASE cycle, then gnt=0b0100.
REQ-037 MAX_HOLD=16, req[3] held -> timeout pulses after 16 override cycles and gnt returns to 0; with req[3] still high no re-grant; req[3] low one cycle then high -> re-granted.
REQ-038 rst during OVERRIDE with ovr_val=0xAA -> next cycle value=0, gnt=0, ovr_active=0, wr_blocked=0.
